counter_arbiter: RTL

Round-robin arbiter that shares one programmable down-counter between `N_REQ` requesters. Each requester presents a count value and holds a request; the arbiter grants one requester at a time, runs the counter for that requester's duration, and returns a one-cycle completion pulse. It sits beside the clock-divider logic as the scheduler for timed intervals (debounce windows, display refresh slots, delays), so the design needs only one wide counter.

---
 rtl/counter_arbiter_if.sv | 23 ++
 rtl/counter_arbiter.sv | 117 +++++++++++
 2 files changed

// File: rtl/counter_arbiter_if.sv
// Requester-side bundle for counter_arbiter: request levels and load values in,
// grant/done/busy and the live counter value out.
interface counter_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 26
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*CNT_W-1:0] load_val;
    logic [N_REQ-1:0]       grant;
    logic [N_REQ-1:0]       done;
    logic                   busy;
    logic [CNT_W-1:0]       cur_cnt;

    modport master (
        output req, load_val,
        input  grant, done, busy, cur_cnt
    );

    modport slave (
        input  req, load_val,
        output grant, done, busy, cur_cnt
    );
endinterface

// File: rtl/counter_arbiter.sv
// Round-robin arbiter sharing one down-counter between N_REQ requesters; the
// owner's interval runs load_val+1 cycles, then a one-cycle done pulse is returned.
module counter_arbiter #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 26
) (
    input  logic             clk_in,
    input  logic             rst,
    counter_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_next;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_ptr_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    logic [CNT_W-1:0] w_load     [N_REQ];
    logic [IDX_W-1:0] w_cand_idx [N_REQ];
    logic [N_REQ-1:0] w_cand_hit;
    logic [N_REQ-1:0] w_owner_oh;
    logic [IDX_W-1:0] w_pick;
    logic             w_any;
    logic [IDX_W-1:0] w_idx_inc;
    logic             w_busy;

    // Candidate gi is requester (ptr + gi) mod N_REQ, so gi = 0 has top priority.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
        logic [IDX_W:0] w_sum;

        assign w_load[gi]     = bus.load_val[gi*CNT_W +: CNT_W];
        assign w_sum          = {1'b0, r_ptr} + (IDX_W+1)'(gi);
        assign w_cand_idx[gi] = (w_sum >= (IDX_W+1)'(N_REQ))
                              ? IDX_W'(w_sum - (IDX_W+1)'(N_REQ))
                              : w_sum[IDX_W-1:0];
        assign w_cand_hit[gi] = bus.req[w_cand_idx[gi]];
        assign w_owner_oh[gi] = (r_idx == IDX_W'(gi));
    end

    always_comb begin
        w_any  = 1'b0;
        w_pick = r_ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_cand_hit[k]) begin
                w_any  = 1'b1;
                w_pick = w_cand_idx[k];
            end
        end
    end

    assign w_idx_inc = (r_idx == IDX_W'(N_REQ - 1)) ? '0 : r_idx + IDX_W'(1);

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_ptr_next   = r_ptr;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_idx_next   = w_pick;
                    w_cnt_next   = w_load[w_pick];
                    w_state_next = S_COUNT;
                end
            end
            S_COUNT: begin
                // Owner dropping its request aborts silently; the counter is left as is.
                if (!bus.req[r_idx]) begin
                    w_state_next = S_IDLE;
                    w_ptr_next   = w_idx_inc;
                end else if (r_cnt == '0) begin
                    w_state_next = S_DONE;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            S_DONE: begin
                w_ptr_next   = w_idx_inc;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_ptr   <= w_ptr_next;
            r_cnt   <= w_cnt_next;
        end
    end

    assign w_busy      = (r_state != S_IDLE);
    assign bus.busy    = w_busy;
    assign bus.grant   = w_busy ? w_owner_oh : '0;
    assign bus.done    = (r_state == S_DONE) ? w_owner_oh : '0;
    assign bus.cur_cnt = r_cnt;

endmodule
